// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
// Instruction-fetch prefetch queue between a 1-cycle-latency instruction SRAM
// and the CPU decode stage. Keeps at most DEPTH instructions queued plus one
// request outstanding. A redirect flushes everything and restarts fetch.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   IM_addr      : instruction SRAM word address (request PC[15:2]), combinational
//   IM_data_in   : instruction SRAM read data, valid one cycle after IM_addr
//   redirect     : taken branch / jump from the CPU
//   redirect_pc  : new fetch PC, sampled while redirect=1
//   inst_valid   : head-of-queue instruction is valid
//   inst_ready   : decode stage accepts the head instruction
//   inst_out     : head-of-queue instruction
//   inst_pc      : PC of inst_out
// ---------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [13:0] IM_addr,
    input  logic [31:0] IM_data_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t             fifo [DEPTH];
    logic [31:0]        fetch_pc;
    logic               inflight;
    logic [31:0]        inflight_pc;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic [OCC_W-1:0]   occupancy;
    logic               issue;
    logic               pop;
    logic               push;

    // Control decode; redirect overrides issue, pop and push in its cycle.
    always_comb begin
        occupancy = OCC_W'(count) + OCC_W'(inflight);
        issue     = !redirect && (occupancy < OCC_W'(DEPTH));
        pop       = inst_valid && inst_ready && !redirect;
        push      = inflight && !redirect;
        // fetch_pc is already RESET_PC while rst is high; ignore redirect then.
        if (redirect && !rst) begin
            IM_addr = redirect_pc[15:2];
        end else begin
            IM_addr = fetch_pc[15:2];
        end
    end

    // Head of queue presented combinationally.
    always_comb begin
        inst_valid = (count != '0);
        inst_out   = fifo[rd_ptr].inst;
        inst_pc    = fifo[rd_ptr].pc;
    end

    // Control state: fetch PC, outstanding request, pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc + 32'd4;
            inflight    <= 1'b1;
            inflight_pc <= redirect_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end else begin
                inflight    <= 1'b0;
            end
        end
    end

    // Queue storage; returning SRAM data is tagged with the PC it was fetched for.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr].pc   <= inflight_pc;
            fifo[wr_ptr].inst <= IM_data_in;
        end
    end

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the queue entry count; legal values are powers of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 IM_addr  output  14  SHALL be the instruction SRAM word address, equal to the request PC bits [15:2].
REQ-006 IM_data_in  input  32  SHALL be the instruction SRAM read data, valid one cycle after its address is presented.
REQ-007 redirect  input  1  SHALL signal a taken branch or jump from the CPU.
REQ-008 redirect_pc  input  32  SHALL give the new fetch PC, sampled when redirect=1.
REQ-009 inst_valid  output  1  SHALL be high when an instruction is presented to the CPU.
REQ-010 inst_ready  input  1  SHALL be high when the CPU decode stage accepts an instruction.
REQ-011 inst_out  output  32  SHALL carry the head-of-queue instruction.
REQ-012 inst_pc  output  32  SHALL carry the PC of inst_out.

Function
REQ-013 State SHALL be: fetch_pc[31:0], inflight bit, inflight_pc[31:0], a DEPTH-entry FIFO of {pc, inst}, rd/wr pointers, and count[log2(DEPTH):0].
REQ-014 inst_valid SHALL equal (count != 0); inst_out and inst_pc SHALL be the head entry, driven combinationally.
REQ-015 Pop: when inst_valid && inst_ready && !redirect, the head entry SHALL be removed at the clock edge.
REQ-016 Request issue (no redirect): a request is issued when (count + inflight) < DEPTH.
REQ-017 On an issued request, IM_addr SHALL be fetch_pc[15:2]; inflight and inflight_pc SHALL be set to 1 and fetch_pc; fetch_pc SHALL advance by 4.
REQ-018 When no request is issued, IM_addr SHALL hold fetch_pc[15:2], and inflight SHALL clear at the next edge.
REQ-019 Return: when inflight=1 and no redirect occurs, {inflight_pc, IM_data_in} SHALL be written at the FIFO tail at the edge.
REQ-020 A simultaneous push and pop SHALL leave count unchanged.
REQ-021 REQ-016 SHALL guarantee that a push never occurs when full; with continuous inst_ready=1, steady-state throughput SHALL be one instruction per cycle.
REQ-022 Redirect SHALL take priority over every other event in its cycle:
  - the FIFO is flushed (count=0, pointers reset);
  - any pending inflight return is discarded;
  - a concurrent pop is void;
  - IM_addr = redirect_pc[15:2] that cycle;
  - inflight=1 with inflight_pc=redirect_pc;
  - fetch_pc <= redirect_pc + 4.
REQ-023 Redirect-to-first-valid latency SHALL be 2 cycles: redirect at cycle N gives inst_valid=1 with inst_pc=redirect_pc at cycle N+2; there is no bypass of an empty queue.
REQ-024 Back-to-back redirects SHALL each restart fetch; only the last target's stream SHALL appear.
REQ-025 fetch_pc SHALL wrap modulo 2^32; IM_addr SHALL wrap 14'h3FFF to 14'h0000 with no special handling.
REQ-026 redirect_pc[1:0] SHALL be ignored for addressing but propagated in inst_pc.

Reset
REQ-027 While rst=1, the block SHALL hold: fetch_pc=RESET_PC, inflight=0, count=0, pointers=0, inst_valid=0, and IM_addr=RESET_PC[15:2].
REQ-028 Reset SHALL act immediately regardless of clk and abort any in-flight request or queued entries.
REQ-029 The first request SHALL issue in the first cycle after rst deasserts, giving the first inst_valid=1 two cycles later with inst_pc=RESET_PC.

Verification
REQ-030 Reset release, inst_ready=1, IM returns the word address as data -> inst_pc 0x0, 0x4, 0x8 ... on consecutive cycles from cycle 2; inst_out matches.
REQ-031 inst_ready=0 for 10 cycles after reset -> count saturates at 4, IM_addr holds 14'h0004, no overwrite; on ready=1, PCs 0x0-0xC drain in order, then 0x10 follows gap-free.
REQ-032 Redirect to 0x0000_0100 while queue is full and a pop is requested -> queue empties, IM_addr=14'h0040 that cycle, inst_pc=0x100 exactly 2 cycles later, no stale PC appears.
REQ-033 Redirect in two consecutive cycles to 0x200 then 0x300 -> no 0x200 instruction delivered; first valid is 0x300.
REQ-034 Redirect to 0xFFFF_FFF8 with ready=1 -> PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; IM_addr 14'h3FFE, 14'h3FFF, 14'h0000.
REQ-035 Assert rst mid-stream with entries queued and a request inflight -> outputs go to reset values asynchronously; after release, sequence restarts at RESET_PC.
